mul_add_top: RTL and testbench

- Matrix-chain multiply-add accelerator: R = X·W0·W1·…·W7 on 16x16 matrices of 16-bit elements.
- Operands arrive over a 32-bit load stream (two elements per beat); the 256 result elements leave over a 32-bit result stream.
- Top-level compute block of the MulAdd accelerator, fed by a host/DMA word stream.

---
 rtl/muladd_pkg.sv | 28 ++
 rtl/muladd_mac_row.sv | 62 ++++++
 rtl/mul_add_top.sv | 209 ++++++++++++++++++++
 tb/tb_mul_add_top.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muladd_pkg.sv
// Shared constants and types for the MulAdd matrix-chain accelerator.
// Holds the element/accumulator widths, matrix geometry, per-phase beat counts
// and the job phase encoding used by mul_add_top and muladd_mac_row.
// Build option: MULADD_SAT_EN (see muladd_mac_row) selects saturating dot products.
package muladd_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned N          = 16;
  localparam int unsigned NUM_LAYERS = 8;
  localparam int unsigned PAY_W      = 2 * DATA_W;
  localparam int unsigned BEATS_L0   = 256;  // X plus W0
  localparam int unsigned BEATS_LW   = 128;  // one weight matrix
  // 16 products of 32 bits each need 36 bits to sum without overflow.
  localparam int unsigned ACC_W      = 36;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef logic signed [DATA_W-1:0] elem_t;

  typedef enum logic [1:0] {
    Load0,   // streaming X and W0
    LoadW,   // streaming W1..W7
    Drain,   // last layer computing, beats ignored
    Output   // result words leaving
  } phase_e;

endpackage

// File: rtl/muladd_mac_row.sv
// 32 signed MACs computing two full output rows of X*W, one k-term per cycle.
// MAC m < 16 uses x_a_i (row 2s) and weight column m; MAC m >= 16 uses x_b_i
// (row 2s+1) and column m-16. first_i restarts the sums. res_o is the reduced
// value of the sum including this cycle's product, so the caller can write it
// back on the final k-term without an extra cycle.
// Ports: clk_data, rst_n (async, active-low), en_i (accumulate), first_i,
//   x_a_i/x_b_i (X elements), w_row_i (W[k][15:0] packed), res_o (32 results).
// Build option: MULADD_SAT_EN defined -> saturate to 16 bits, else wrap.
module muladd_mac_row
  import muladd_pkg::*;
(
  input  logic                      clk_data,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      first_i,
  input  logic [DATA_W-1:0]         x_a_i,
  input  logic [DATA_W-1:0]         x_b_i,
  input  logic [N*DATA_W-1:0]       w_row_i,
  output logic [2*N*DATA_W-1:0]     res_o
);

  localparam int unsigned NumMac = 2 * N;

  logic signed [ACC_W-1:0] acc_q [NumMac];
  logic signed [ACC_W-1:0] acc_d [NumMac];

  function automatic elem_t reduce_acc(input logic signed [ACC_W-1:0] a);
`ifdef MULADD_SAT_EN
    if (a > SAT_MAX) return elem_t'(SAT_MAX[DATA_W-1:0]);
    if (a < SAT_MIN) return elem_t'(SAT_MIN[DATA_W-1:0]);
    return elem_t'(a[DATA_W-1:0]);
`else
    return elem_t'(a[DATA_W-1:0]);
`endif
  endfunction

  always_comb begin
    elem_t                   xv;
    elem_t                   wv;
    logic signed [ACC_W-1:0] base;
    xv    = '0;
    wv    = '0;
    base  = '0;
    res_o = '0;
    for (int unsigned m = 0; m < NumMac; m++) begin
      xv       = (m < N) ? $signed(x_a_i) : $signed(x_b_i);
      wv       = $signed(w_row_i[(m % N)*DATA_W +: DATA_W]);
      base     = first_i ? '0 : acc_q[m];
      acc_d[m] = base + ACC_W'(xv) * ACC_W'(wv);
      res_o[m*DATA_W +: DATA_W] = reduce_acc(acc_d[m]);
    end
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned m = 0; m < NumMac; m++) acc_q[m] <= '0;
    end else if (en_i) begin
      for (int unsigned m = 0; m < NumMac; m++) acc_q[m] <= acc_d[m];
    end
  end

endmodule

// File: rtl/mul_add_top.sv
// MulAdd accelerator top: R = X*W0*...*W7 on 16x16 signed 16-bit matrices.
// A job is 256 beats of X/W0 followed by 7x128 beats of W1..W7 (two elements
// per beat, skewed order decoded below). Weights are double-buffered so layer j
// computes (128 cycles on 32 MACs, result written back into X) while layer j+1
// loads. After the last layer, 128 result words stream out; beats arriving in
// Drain/Output are ignored.
// Ports: clk_data, rst_n (async, active-low), load_en_i, load_payload_i[31:0]
//   (hi/lo element), result_valid_o, result_payload_o[31:0] (hi/lo result,
//   held when not valid).
// Build option: MULADD_SAT_EN -> saturating dot products (see muladd_mac_row).
module mul_add_top
  import muladd_pkg::*;
(
  input  logic        clk_data,
  input  logic        rst_n,
  input  logic        load_en_i,
  input  logic [31:0] load_payload_i,
  output logic        result_valid_o,
  output logic [31:0] result_payload_o
);

  phase_e      phase_q, phase_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [2:0]  layer_q, layer_d;      // weight layer currently loading
  logic [6:0]  out_cnt_q, out_cnt_d;
  logic        comp_active_q, comp_active_d;
  logic        comp_buf_q, comp_buf_d;
  logic        comp_last_q, comp_last_d;
  logic [6:0]  comp_cnt_q, comp_cnt_d;  // {row pair s, k}
  logic [PAY_W-1:0] hold_q;

  logic [DATA_W-1:0] x_q [N][N];
  logic [DATA_W-1:0] w_q [2][N][N];

  // Load address decode. Within a group, beat b carries index 15-2(b-1) high
  // and 14-2(b-1) low; for W1..W7 the column is skewed by the group number.
  logic       beat, ld_x_we, ld_w_we, ld_w_buf;
  logic [2:0] bb;
  logic [3:0] pos_hi, pos_lo, h, l, w_col_hi, w_col_lo;

  always_comb begin
    beat     = load_en_i && (phase_q == Load0 || phase_q == LoadW);
    bb       = beat_cnt_q[2:0];
    pos_hi   = {~bb, 1'b1};
    pos_lo   = {~bb, 1'b0};
    h        = beat_cnt_q[6:3] + {bb, 1'b0};
    l        = h + 4'd1;
    ld_x_we  = beat && (phase_q == Load0) && !beat_cnt_q[3];
    ld_w_we  = beat && !((phase_q == Load0) && !beat_cnt_q[3]);
    ld_w_buf = (phase_q == LoadW) ? layer_q[0] : 1'b0;
    w_col_hi = (phase_q == Load0) ? beat_cnt_q[7:4] : ~h;
    w_col_lo = (phase_q == Load0) ? beat_cnt_q[7:4] : ~l;
  end

  // Compute datapath
  logic [2:0]             s;
  logic [3:0]             kk;
  logic                   mac_last;
  logic [DATA_W-1:0]      x_a, x_b;
  logic [N*DATA_W-1:0]    w_row;
  logic [2*N*DATA_W-1:0]  mac_res;

  always_comb begin
    s        = comp_cnt_q[6:4];
    kk       = comp_cnt_q[3:0];
    mac_last = comp_active_q && (kk == 4'd15);
    x_a      = x_q[{s, 1'b0}][kk];
    x_b      = x_q[{s, 1'b1}][kk];
    w_row    = '0;
    for (int unsigned c = 0; c < N; c++) w_row[c*DATA_W +: DATA_W] = w_q[comp_buf_q][kk][c];
  end

  muladd_mac_row u_mac_row (
    .clk_data (clk_data),
    .rst_n    (rst_n),
    .en_i     (comp_active_q),
    .first_i  (kk == 4'd0),
    .x_a_i    (x_a),
    .x_b_i    (x_b),
    .w_row_i  (w_row),
    .res_o    (mac_res)
  );

  // Job sequencing
  logic comp_start, start_buf, start_last;

  always_comb begin
    phase_d    = phase_q;
    beat_cnt_d = beat_cnt_q;
    layer_d    = layer_q;
    out_cnt_d  = out_cnt_q;
    comp_start = 1'b0;
    start_buf  = 1'b0;
    start_last = 1'b0;
    unique case (phase_q)
      Load0: if (beat) begin
        if (beat_cnt_q == 8'(BEATS_L0 - 1)) begin
          beat_cnt_d = '0;
          layer_d    = 3'd1;
          phase_d    = LoadW;
          comp_start = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      LoadW: if (beat) begin
        if (beat_cnt_q == 8'(BEATS_LW - 1)) begin
          beat_cnt_d = '0;
          comp_start = 1'b1;
          start_buf  = layer_q[0];
          start_last = (layer_q == 3'(NUM_LAYERS - 1));
          if (start_last) phase_d = Drain;
          else            layer_d = layer_q + 3'd1;
        end else begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      Drain: if (comp_active_q && comp_last_q && comp_cnt_q == 7'd127) begin
        phase_d   = Output;
        out_cnt_d = '0;
      end
      Output: begin
        out_cnt_d = out_cnt_q + 7'd1;
        if (out_cnt_q == 7'd127) begin
          phase_d = Load0;
          layer_d = '0;
        end
      end
      default: phase_d = Load0;
    endcase

    comp_active_d = comp_active_q;
    comp_buf_d    = comp_buf_q;
    comp_last_d   = comp_last_q;
    comp_cnt_d    = comp_cnt_q;
    if (comp_start) begin
      comp_active_d = 1'b1;
      comp_buf_d    = start_buf;
      comp_last_d   = start_last;
      comp_cnt_d    = '0;
    end else if (comp_active_q) begin
      comp_cnt_d = comp_cnt_q + 7'd1;
      if (comp_cnt_q == 7'd127) comp_active_d = 1'b0;
    end
  end

  // Output word: k outer, i inner; low = R[2i][k], high = R[2i+1][k]
  logic [PAY_W-1:0] out_word;
  always_comb begin
    out_word         = {x_q[{out_cnt_q[2:0], 1'b1}][out_cnt_q[6:3]],
                        x_q[{out_cnt_q[2:0], 1'b0}][out_cnt_q[6:3]]};
    result_valid_o   = (phase_q == Output);
    result_payload_o = result_valid_o ? out_word : hold_q;
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= Load0;
      beat_cnt_q    <= '0;
      layer_q       <= '0;
      out_cnt_q     <= '0;
      comp_active_q <= 1'b0;
      comp_buf_q    <= 1'b0;
      comp_last_q   <= 1'b0;
      comp_cnt_q    <= '0;
      hold_q        <= '0;
    end else begin
      phase_q       <= phase_d;
      beat_cnt_q    <= beat_cnt_d;
      layer_q       <= layer_d;
      out_cnt_q     <= out_cnt_d;
      comp_active_q <= comp_active_d;
      comp_buf_q    <= comp_buf_d;
      comp_last_q   <= comp_last_d;
      comp_cnt_q    <= comp_cnt_d;
      if (result_valid_o) hold_q <= out_word;
    end
  end

  // Matrix storage. Rows 2s/2s+1 of X are only read by step s, so the layer
  // result can overwrite them in place on the step's last k-term.
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          x_q[r][c]    <= '0;
          w_q[0][r][c] <= '0;
          w_q[1][r][c] <= '0;
        end
      end
    end else begin
      if (ld_x_we) begin
        x_q[beat_cnt_q[7:4]][pos_hi] <= load_payload_i[31:16];
        x_q[beat_cnt_q[7:4]][pos_lo] <= load_payload_i[15:0];
      end
      if (mac_last) begin
        for (int unsigned c = 0; c < N; c++) begin
          x_q[{s, 1'b0}][c] <= mac_res[c*DATA_W +: DATA_W];
          x_q[{s, 1'b1}][c] <= mac_res[(N+c)*DATA_W +: DATA_W];
        end
      end
      if (ld_w_we) begin
        w_q[ld_w_buf][pos_hi][w_col_hi] <= load_payload_i[31:16];
        w_q[ld_w_buf][pos_lo][w_col_lo] <= load_payload_i[15:0];
      end
    end
  end

endmodule

// File: tb/tb_mul_add_top.sv
module tb_mul_add_top;

  logic        clk_data = 1'b0;
  logic        rst_n;
  logic        load_en_i;
  logic [31:0] load_payload_i;
  logic        result_valid_o;
  logic [31:0] result_payload_o;

  always #5 clk_data = ~clk_data;

  mul_add_top dut (
    .clk_data         (clk_data),
    .rst_n            (rst_n),
    .load_en_i        (load_en_i),
    .load_payload_i   (load_payload_i),
    .result_valid_o   (result_valid_o),
    .result_payload_o (result_payload_o)
  );

  int total;
  int bad;

  logic signed [15:0] mx [16][16];
  logic signed [15:0] mw [8][16][16];
  logic [31:0]        exp_words [128];

  // X kinds: 0 ramp 16r+c, 1 random, 2 all ones, 3 0x7FFF diagonal
  // W kinds: 0 I, 1 zero, 2 all ones, 3 2*I, 4 random
  typedef struct {
    int          xk;
    int          wk;
    int          sp_layer;
    int          sp_kind;
    bit          gaps;
    bit          junk;
    bit          spot;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

`ifdef MULADD_SAT_EN
  localparam logic [31:0] OnesExp = 32'h7fff_7fff;
  localparam logic [31:0] DiagExp = 32'h0000_7fff;
`else
  localparam logic [31:0] OnesExp = 32'h0000_0000;
  localparam logic [31:0] DiagExp = 32'h0000_fffe;
`endif

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic signed [15:0] reduce(input longint v);
`ifdef MULADD_SAT_EN
    if (v > 32767) return 16'sh7fff;
    if (v < -32768) return 16'sh8000;
`endif
    return 16'(v);
  endfunction

  task automatic build_model();
    logic signed [15:0] cur [16][16];
    logic signed [15:0] nxt [16][16];
    longint acc;
    cur = mx;
    for (int ly = 0; ly < 8; ly++) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) begin
          acc = 0;
          for (int k = 0; k < 16; k++) acc += longint'(cur[r][k]) * longint'(mw[ly][k][c]);
          nxt[r][c] = reduce(acc);
        end
      cur = nxt;
    end
    for (int k = 0; k < 16; k++)
      for (int i = 0; i < 8; i++) exp_words[k*8+i] = {cur[2*i+1][k], cur[2*i][k]};
  endtask

  task automatic set_x(input int kind);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        case (kind)
          0: mx[r][c] = 16'(16*r + c);
          1: mx[r][c] = 16'($urandom);
          2: mx[r][c] = 16'sd1;
          default: mx[r][c] = (r == c) ? 16'sh7fff : 16'sd0;
        endcase
  endtask

  task automatic set_w(input int ly, input int kind);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        case (kind)
          0: mw[ly][r][c] = (r == c) ? 16'sd1 : 16'sd0;
          1: mw[ly][r][c] = 16'sd0;
          2: mw[ly][r][c] = 16'sd1;
          3: mw[ly][r][c] = (r == c) ? 16'sd2 : 16'sd0;
          default: mw[ly][r][c] = 16'($urandom);
        endcase
  endtask

  task automatic send_beat(input logic [31:0] p, input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 3) == 0) begin
      n = $urandom_range(1, 24);
      load_en_i = 1'b0;
      repeat (n) @(posedge clk_data);
      #1;
    end
    load_en_i      = 1'b1;
    load_payload_i = p;
    @(posedge clk_data);
    #1;
    load_en_i = 1'b0;
  endtask

  // Streams one job in the specified beat order; stops before beat abort_at.
  task automatic stream_job(input bit gaps, input int abort_at);
    int n;
    int h;
    int l;
    logic [31:0] p;
    n = 0;
    for (int g = 0; g < 32; g++)
      for (int b = 1; b <= 8; b++) begin
        if (n == abort_at) return;
        if (g % 2 == 0) p = {mx[g/2][17-2*b], mx[g/2][16-2*b]};
        else            p = {mw[0][17-2*b][(g-1)/2], mw[0][16-2*b][(g-1)/2]};
        send_beat(p, gaps);
        n++;
      end
    for (int j = 1; j < 8; j++)
      for (int k = 0; k < 16; k++)
        for (int b = 1; b <= 8; b++) begin
          if (n == abort_at) return;
          h = (k + 2*b - 2) % 16;
          l = (k + 2*b - 1) % 16;
          p = {mw[j][17-2*b][15-h], mw[j][16-2*b][15-l]};
          send_beat(p, gaps);
          n++;
        end
  endtask

  task automatic collect(input string tag, input bit junk, input bit spot,
                         input logic [31:0] e0, input logic [31:0] e1);
    int n;
    bit all_valid;
    logic [31:0] got0;
    logic [31:0] got1;
    n = 0;
    do begin
      @(negedge clk_data);
      n++;
    end while (!result_valid_o && n < 400);
    total++;
    if (!result_valid_o || n > 161) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles valid=%b, want <=161 cycles valid=1",
               tag, n, result_valid_o);
    end
    if (!result_valid_o) return;
    all_valid = 1'b1;
    got0 = '0;
    got1 = '0;
    for (int idx = 0; idx < 128; idx++) begin
      if (idx > 0) @(negedge clk_data);
      all_valid &= result_valid_o;
      if (idx == 0) got0 = result_payload_o;
      if (idx == 1) got1 = result_payload_o;
      check($sformatf("%s word%0d", tag, idx), result_payload_o, exp_words[idx]);
      if (junk && idx < 127) begin
        load_en_i      = 1'b1;
        load_payload_i = $urandom;
      end else begin
        load_en_i = 1'b0;
      end
    end
    load_en_i = 1'b0;
    check({tag, " valid_run"}, 32'(all_valid), 32'd1);
    if (spot) begin
      check({tag, " spot0"}, got0, e0);
      check({tag, " spot1"}, got1, e1);
    end
    @(negedge clk_data);
    check({tag, " valid_end"}, 32'(result_valid_o), 32'd0);
    check({tag, " hold"}, result_payload_o, exp_words[127]);
  endtask

  task automatic setup(input vec_t v);
    set_x(v.xk);
    for (int ly = 0; ly < 8; ly++) set_w(ly, v.wk);
    if (v.sp_layer >= 0) set_w(v.sp_layer, v.sp_kind);
    build_model();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idv;
    total          = 0;
    bad            = 0;
    rst_n          = 1'b0;
    load_en_i      = 1'b0;
    load_payload_i = '0;

    vecs[0] = '{0, 0, -1, 0, 1'b0, 1'b0, 1'b1, 32'h0010_0000, 32'h0030_0020};
    vecs[1] = '{1, 0,  3, 1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{2, 2, -1, 0, 1'b0, 1'b0, 1'b1, OnesExp, OnesExp};
    vecs[3] = '{0, 0,  7, 3, 1'b0, 1'b0, 1'b1, 32'h0020_0000, 32'h0060_0040};
    vecs[4] = '{3, 0,  0, 3, 1'b0, 1'b0, 1'b1, DiagExp, 32'h0000_0000};
    vecs[5] = '{0, 0, -1, 0, 1'b1, 1'b1, 1'b1, 32'h0010_0000, 32'h0030_0020};
    vecs[6] = '{1, 4, -1, 0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[7] = '{1, 4, -1, 0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

    repeat (3) @(posedge clk_data);
    @(negedge clk_data);
    check("reset valid", 32'(result_valid_o), 32'd0);
    check("reset payload", result_payload_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk_data);
    #1;

    for (int v = 0; v < 8; v++) begin
      setup(vecs[v]);
      stream_job(vecs[v].gaps, -1);
      collect($sformatf("v%0d", v), vecs[v].junk, vecs[v].spot, vecs[v].e0, vecs[v].e1);
    end

    // Reset at beat 300 of an identity job, then a fresh identity job.
    idv = vecs[0];
    setup(idv);
    stream_job(1'b0, 300);
    rst_n = 1'b0;
    #1;
    check("midreset valid", 32'(result_valid_o), 32'd0);
    check("midreset payload", result_payload_o, 32'd0);
    repeat (3) @(negedge clk_data);
    check("midreset valid late", 32'(result_valid_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk_data);
    #1;
    stream_job(1'b0, -1);
    collect("postreset", 1'b0, 1'b1, idv.e0, idv.e1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
